// File: rtl/exception_sequencer.sv
// Exception sequencer: latches the highest-priority exception cause and saves
// the faulting PC (pc_in - 4) into epc_out. It then fetches the handler byte from
// the vector address, which takes MEM_WAIT cycles, pulses pc_load with the
// handler address, and finally pulses exc_done. A request seen while busy
// sets the sticky exc_lost flag.
module exception_sequencer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_en,
  input  logic        opcode_invalid,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_data_in,
  output logic [1:0]  exceptions_control,
  output logic        mem_addr_sel,
  output logic        mem_read,
  output logic [31:0] epc_out,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        exc_active,
  output logic        exc_done,
  output logic        exc_lost
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SAVE = 3'd1,
    READ = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0] READ_LOAD = 4'(MEM_WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_pc;
  logic [3:0]  r_cnt;
  logic        r_lost;

  logic        w_req;
  logic        w_accept;
  logic        w_read_last;
  logic [1:0]  w_cause;

  assign w_req       = opcode_invalid | overflow | div_zero;
  assign w_accept    = (r_state == IDLE) && exc_en && w_req;
  assign w_read_last = (r_state == READ) && (r_cnt == '0);

  // Fixed-priority encode of the simultaneous requests
  always_comb begin
    w_cause = 2'd2;
    if (opcode_invalid)
      w_cause = 2'd0;
    else if (overflow)
      w_cause = 2'd1;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SAVE;
      SAVE:    w_next = READ;
      READ:    if (r_cnt == '0) w_next = LOAD;
      LOAD:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Cause latch, EPC save, read-wait counter and handler capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cause <= '0;
      r_epc   <= '0;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept)
        r_cause <= w_cause;
      if (r_state == SAVE) begin
        r_epc <= pc_in - 32'd4;
        r_cnt <= READ_LOAD;
      end else if ((r_state == READ) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_read_last)
        r_pc <= {24'b0, mem_data_in};
    end
  end

  // Sticky flag for requests that arrive while a sequence is in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_lost <= 1'b0;
    else if ((r_state != IDLE) && w_req)
      r_lost <= 1'b1;
  end

  assign exceptions_control = r_cause;
  assign epc_out            = r_epc;
  assign pc_out             = r_pc;
  assign exc_lost           = r_lost;
  assign exc_active         = (r_state != IDLE);
  assign mem_read           = (r_state == READ);
  assign mem_addr_sel       = (r_state == READ);
  assign pc_load            = (r_state == LOAD);
  assign exc_done           = (r_state == DONE);

endmodule
